// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard / stall sequencer.
// Holds the sequencer state encoding, default MDU latencies and the
// architectural zero register number.
package hazard_pkg;

    // Sequencer states: normal issue, or EX held by a multi-cycle MUL/DIV.
    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_BUSY = 1'b1
    } hz_state_t;

    // Default number of cycles a multiply / divide occupies EX.
    localparam int unsigned MUL_LAT_DEF = 4;
    localparam int unsigned DIV_LAT_DEF = 12;

    // Register 0 is hardwired to zero and never produces a hazard.
    localparam int unsigned REG_ZERO = 0;

endpackage : hazard_pkg

// File: rtl/mdu_lat_counter.sv
// Down-counter tracking the remaining EX cycles of an MDU operation.
// Load has priority over decrement; the counter never wraps below zero.
module mdu_lat_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_is_one
);

    logic [CNT_W-1:0] r_count;

    // Counter register: cleared on reset, loaded on op start, decremented while busy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Flags the final cycle of the operation.
    assign o_is_one = (r_count == CNT_W'(1));

endmodule : mdu_lat_counter

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall sequencer for the 5-stage core.
// Detects load-use hazards, flushes the front end on EX redirects and holds
// EX for the multi-cycle MDU. State is visible externally through o_mdu_busy
// (1 exactly when the sequencer is in ST_MDU_BUSY).
// Optional macro HAZ_PERF_CNT_EN adds stall / flush / MDU-op counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W   = 6,
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF,
    parameter int unsigned CNT_W   = 4
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int unsigned PERF_W  = 32
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [REG_W-1:0]  i_IF_ID_Rs,
    input  logic [REG_W-1:0]  i_IF_ID_Rt,
    input  logic              i_ID_uses_Rt,
    input  logic [REG_W-1:0]  i_ID_EX_Rt,
    input  logic              i_ID_EX_mem_read,
    input  logic              i_EX_redirect,
    input  logic              i_EX_mdu_start,
    input  logic              i_EX_mdu_is_div,
    output logic              o_pc_write,
    output logic              o_IF_ID_write,
    output logic              o_IF_ID_flush,
    output logic              o_ID_EX_write,
    output logic              o_ID_EX_flush,
    output logic              o_EX_MEM_bubble,
    output logic              o_mdu_busy,
    output logic              o_mdu_done
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] o_stall_cycles,
    output logic [PERF_W-1:0] o_flush_events,
    output logic [PERF_W-1:0] o_mdu_ops
`endif
);

    // The counter is loaded with LAT-1: the start cycle in RUN is the first EX cycle.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    hz_state_t        r_state;
    hz_state_t        w_state_next;
    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic [CNT_W-1:0] w_cnt_load_val;
    logic             w_cnt_is_one;
    logic             w_load_use;
    logic             w_chk_load_use;
    logic             w_redirect_acc;
    logic             w_mdu_begin;

    mdu_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_is_one   (w_cnt_is_one)
    );

    // Load-use: a load in EX targets a non-zero register the ID instruction reads.
    assign w_load_use = i_ID_EX_mem_read
                     && (i_ID_EX_Rt != REG_W'(REG_ZERO))
                     && ((i_ID_EX_Rt == i_IF_ID_Rs)
                         || (i_ID_uses_Rt && (i_ID_EX_Rt == i_IF_ID_Rt)));

    assign w_cnt_load_val = i_EX_mdu_is_div ? DIV_LOAD : MUL_LOAD;
    assign o_mdu_busy     = (r_state == ST_MDU_BUSY);

    // State register; a reset abandons any MDU operation in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and pipeline controls: redirect > MDU stall > load-use.
    always_comb begin
        w_state_next    = r_state;
        o_pc_write      = 1'b1;
        o_IF_ID_write   = 1'b1;
        o_IF_ID_flush   = 1'b0;
        o_ID_EX_write   = 1'b1;
        o_ID_EX_flush   = 1'b0;
        o_EX_MEM_bubble = 1'b0;
        o_mdu_done      = 1'b0;
        w_cnt_load      = 1'b0;
        w_cnt_dec       = 1'b0;
        w_chk_load_use  = 1'b0;
        w_redirect_acc  = 1'b0;
        w_mdu_begin     = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (i_EX_redirect) begin
                    // PC takes the branch target; both younger stages are squashed.
                    o_IF_ID_flush  = 1'b1;
                    o_ID_EX_flush  = 1'b1;
                    w_redirect_acc = 1'b1;
                end else if (i_EX_mdu_start) begin
                    o_pc_write      = 1'b0;
                    o_IF_ID_write   = 1'b0;
                    o_ID_EX_write   = 1'b0;
                    o_EX_MEM_bubble = 1'b1;
                    w_cnt_load      = 1'b1;
                    w_mdu_begin     = 1'b1;
                    w_state_next    = ST_MDU_BUSY;
                end else begin
                    w_chk_load_use = 1'b1;
                end
            end
            ST_MDU_BUSY: begin
                if (w_cnt_is_one) begin
                    // Last EX cycle: the op advances at this edge; counter drops to 0.
                    o_mdu_done     = 1'b1;
                    w_cnt_dec      = 1'b1;
                    w_chk_load_use = 1'b1;
                    w_state_next   = ST_RUN;
                end else begin
                    o_pc_write      = 1'b0;
                    o_IF_ID_write   = 1'b0;
                    o_ID_EX_write   = 1'b0;
                    o_EX_MEM_bubble = 1'b1;
                    w_cnt_dec       = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase

        if (w_chk_load_use && w_load_use) begin
            o_pc_write    = 1'b0;
            o_IF_ID_write = 1'b0;
            o_ID_EX_flush = 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [PERF_W-1:0] r_stall_cycles;
    logic [PERF_W-1:0] r_flush_events;
    logic [PERF_W-1:0] r_mdu_ops;

    // Performance counters; all wrap naturally at 2^PERF_W.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
            r_mdu_ops      <= '0;
        end else begin
            if (!o_pc_write) begin
                r_stall_cycles <= r_stall_cycles + PERF_W'(1);
            end
            if (w_redirect_acc) begin
                r_flush_events <= r_flush_events + PERF_W'(1);
            end
            if (w_mdu_begin) begin
                r_mdu_ops <= r_mdu_ops + PERF_W'(1);
            end
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_events = r_flush_events;
    assign o_mdu_ops      = r_mdu_ops;
`endif

endmodule : hazard_ctrl

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and stall sequencer for the 5-stage core; sits beside the EX forwarding unit.
- Detects load-use hazards.
- Flushes the front end on taken branches and jumps resolved in EX.
- Holds EX for the multi-cycle multiply/divide unit (MDU) via an internal latency FSM.
- Drives the write-enable and flush controls of PC, IF_ID, ID_EX and EX_MEM.

Parameters:
REG_W, 6, register-address width (matches forwarding-unit Rs/Rt/Rd width)
MUL_LAT, 4, cycles a multiply occupies EX (>=2)
DIV_LAT, 12, cycles a divide occupies EX (>=2)
CNT_W, 4, latency counter width; must hold max(MUL_LAT,DIV_LAT)-1
PERF_W, 32, width of performance counters (optional feature only)

Ports:
i_clk  in  1  core clock
i_rst_n  in  1  reset
i_IF_ID_Rs  in  REG_W  Rs of instruction in ID
i_IF_ID_Rt  in  REG_W  Rt of instruction in ID
i_ID_uses_Rt  in  1  ID instruction reads Rt as a source
i_ID_EX_Rt  in  REG_W  destination of instruction in EX (load target)
i_ID_EX_mem_read  in  1  instruction in EX is a load
i_EX_redirect  in  1  taken branch or jump resolved in EX this cycle
i_EX_mdu_start  in  1  instruction in EX is a MUL/DIV
i_EX_mdu_is_div  in  1  qualifies i_EX_mdu_start: 1=divide, 0=multiply
o_pc_write  out  1  PC update enable
o_IF_ID_write  out  1  IF_ID register load enable
o_IF_ID_flush  out  1  IF_ID cleared to NOP
o_ID_EX_write  out  1  ID_EX load enable (0 = hold EX)
o_ID_EX_flush  out  1  bubble inserted into ID_EX
o_EX_MEM_bubble  out  1  bubble (reg_write/mem_write cleared) inserted into EX_MEM
o_mdu_busy  out  1  registered; FSM in MDU_BUSY
o_mdu_done  out  1  last EX cycle of an MDU op

Behaviour:
- Reset: asynchronous and active-low on i_rst_n; one clock i_clk. Reset sets state RUN, counter 0, perf counters 0. Reset mid-MDU-op abandons the op.
- Reset output values (all inputs 0): o_pc_write=1, o_IF_ID_write=1, o_ID_EX_write=1, o_IF_ID_flush=0, o_ID_EX_flush=0, o_EX_MEM_bubble=0, o_mdu_busy=0, o_mdu_done=0.
- FSM states: RUN, MDU_BUSY. All outputs except o_mdu_busy are combinational from state, counter and inputs.
- RUN, i_EX_redirect=1 (highest priority):
  - o_IF_ID_flush=1, o_ID_EX_flush=1, PC writes the target.
  - i_EX_mdu_start and load-use are ignored that cycle.
  - Next state RUN.
- RUN, i_EX_mdu_start=1, no redirect (MDU stall):
  - Load counter with LAT-1, where LAT = DIV_LAT if i_EX_mdu_is_div else MUL_LAT.
  - Next state MDU_BUSY.
  - Stall this cycle: pc_write=0, IF_ID_write=0, ID_EX_write=0, EX_MEM_bubble=1.
- MDU_BUSY, counter>1:
  - Same stall outputs as the MDU stall; counter decrements.
  - i_EX_mdu_start and i_EX_redirect are ignored.
- MDU_BUSY, counter==1:
  - o_mdu_done=1; no MDU stall, so the op leaves EX at this edge.
  - Next state RUN, counter 0.
- MDU occupancy: the op occupies EX for exactly LAT cycles and EX_MEM receives exactly LAT-1 bubbles.
- Load-use hazard:
  - Condition: i_ID_EX_mem_read, i_ID_EX_Rt!=0, and (i_ID_EX_Rt==i_IF_ID_Rs, or (i_ID_uses_Rt and i_ID_EX_Rt==i_IF_ID_Rt)).
  - Evaluated when no redirect and no MDU stall (RUN, or the MDU_BUSY done cycle).
  - Response: pc_write=0, IF_ID_write=0, o_ID_EX_flush=1. Exactly one bubble; the condition clears the next cycle.
- Register 0 never causes a stall.
- o_mdu_busy is 1 in every MDU_BUSY cycle, including the done cycle.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: adds outputs o_stall_cycles, o_flush_events, o_mdu_ops (PERF_W each, reset 0, wrap modulo 2^PERF_W).
  - o_stall_cycles: +1 on each cycle with pc_write=0.
  - o_flush_events: +1 on each accepted redirect.
  - o_mdu_ops: +1 on each RUN->MDU_BUSY transition.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- hazard_pkg: state encoding (RUN, MDU_BUSY), MUL_LAT/DIV_LAT defaults, REG_ZERO constant.
- One sub-module, mdu_lat_counter: load/decrement counter with is-one flag, instantiated once.

Test Plan:
- Load-use: ID_EX_mem_read=1, ID_EX_Rt=5, IF_ID_Rs=5 -> one cycle of pc_write=0, IF_ID_write=0, ID_EX_flush=1; next cycle (mem_read=0) all normal. With Rt=0 -> no stall.
- Rt-only match: IF_ID_Rt=7, ID_EX_Rt=7, mem_read=1 -> stall when ID_uses_Rt=1; no stall when ID_uses_Rt=0.
- Multiply, start held high while in EX -> pc_write=0 for 3 cycles, o_mdu_done on the 4th, 3 EX_MEM bubbles, then RUN. Divide -> 11 stall cycles, done on the 12th.
- Redirect with mdu_start and load-use asserted in the same RUN cycle -> IF_ID_flush=ID_EX_flush=1, pc_write=1, state stays RUN.
- Reset asserted mid-divide (counter=6) -> outputs immediately at reset values; after release, start=0 gives no stall.
- HAZ_PERF_CNT_EN defined: one load-use, one multiply, one redirect -> stall_cycles=4, flush_events=1, mdu_ops=1.
